rr_req_arbiter: RTL and testbench

- Round-robin arbiter that shares one downstream resource among 4 requesters.
- Picks one requester and holds its grant until the owner releases it, or until a hold-time limit forces release.
- Sits between request sources and the shared datapath; gnt_id drives the datapath select mux.

---
 rtl/rr_arb_pkg.sv | 16 +
 rtl/rr_req_arbiter_if.sv | 22 ++
 rtl/rr_pick4.sv | 38 +++
 rtl/rr_req_arbiter.sv | 118 +++++++++++
 tb/tb_rr_req_arbiter.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the 4-way round-robin request arbiter.
package rr_arb_pkg;

   localparam int N_REQ = 4;
   localparam int ID_W  = 2;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

   function automatic logic [N_REQ-1:0] onehot4(input logic [ID_W-1:0] id);
      return N_REQ'(1) << id;
   endfunction

endpackage

// File: rtl/rr_req_arbiter_if.sv
// Request/grant bundle between the request sources and the round-robin arbiter.
interface rr_req_arbiter_if;
   import rr_arb_pkg::*;

   logic [N_REQ-1:0] req;
   logic             done;
   logic [N_REQ-1:0] gnt;
   logic [ID_W-1:0]  gnt_id;
   logic             gnt_valid;
   logic             timeout;

   modport master (
      output req, done,
      input  gnt, gnt_id, gnt_valid, timeout
   );

   modport slave (
      input  req, done,
      output gnt, gnt_id, gnt_valid, timeout
   );

endinterface

// File: rtl/rr_pick4.sv
// Combinational round-robin winner search: first set request after last_id, wrapping mod 4.
module rr_pick4
   import rr_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  last_id,
   output logic [ID_W-1:0]  win_id,
   output logic             win_valid
);

   logic [ID_W-1:0]  offset;
   logic [N_REQ-1:0] rot;
   logic [ID_W-1:0]  enc;

   assign offset = last_id + ID_W'(1);

   // rot[0] is the requester just after the previous owner, so a plain
   // lowest-index-first encode yields the round-robin choice.
   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_rot
         logic [ID_W-1:0] src;
         assign src     = ID_W'(gi) + offset;
         assign rot[gi] = req[src];
      end
   endgenerate

   always_comb begin
      enc = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) enc = ID_W'(i);
      end
   end

   assign win_id    = enc + offset;
   assign win_valid = |req;

endmodule

// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter for 4 requesters with grant held until done/req drop.
// Define RR_ARB_TIMEOUT_EN to add the MAX_HOLD forced release and timeout pulse.
module rr_req_arbiter
   import rr_arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
) (
   input  logic              clk,
   input  logic              rst,
   rr_req_arbiter_if.slave   bus
);

   generate
      if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
         $error("rr_req_arbiter: MAX_HOLD must be in 2..255");
      end
   endgenerate

   arb_state_t       state_reg,   state_next;
   logic [N_REQ-1:0] gnt_reg,     gnt_next;
   logic [ID_W-1:0]  gnt_id_reg,  gnt_id_next;
   logic [ID_W-1:0]  last_id_reg, last_id_next;
   logic [ID_W-1:0]  win_id;
   logic             win_valid;
   logic             owner_drop;
   logic             limit_hit;

`ifdef RR_ARB_TIMEOUT_EN
   logic [7:0] hold_cnt_reg, hold_cnt_next;
   logic       timeout_reg,  timeout_next;

   assign limit_hit = (hold_cnt_reg == 8'(MAX_HOLD - 1));
`else
   assign limit_hit = 1'b0;
`endif

   rr_pick4 u_pick (
      .req       (bus.req),
      .last_id   (last_id_reg),
      .win_id    (win_id),
      .win_valid (win_valid)
   );

   assign owner_drop = ~bus.req[gnt_id_reg];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= ARB_IDLE;
         gnt_reg     <= '0;
         gnt_id_reg  <= '0;
         last_id_reg <= ID_W'(N_REQ - 1);
`ifdef RR_ARB_TIMEOUT_EN
         hold_cnt_reg <= '0;
         timeout_reg  <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         gnt_reg     <= gnt_next;
         gnt_id_reg  <= gnt_id_next;
         last_id_reg <= last_id_next;
`ifdef RR_ARB_TIMEOUT_EN
         hold_cnt_reg <= hold_cnt_next;
         timeout_reg  <= timeout_next;
`endif
      end
   end

   always_comb begin
      state_next   = state_reg;
      gnt_next     = gnt_reg;
      gnt_id_next  = gnt_id_reg;
      last_id_next = last_id_reg;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt_next = hold_cnt_reg;
      timeout_next  = 1'b0;
`endif
      case (state_reg)
         ARB_IDLE: begin
            gnt_next    = '0;
            gnt_id_next = '0;
            if (win_valid) begin
               state_next  = ARB_GRANT;
               gnt_next    = onehot4(win_id);
               gnt_id_next = win_id;
`ifdef RR_ARB_TIMEOUT_EN
               hold_cnt_next = '0;
`endif
            end
         end
         ARB_GRANT: begin
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt_next = (hold_cnt_reg == 8'hFF) ? hold_cnt_reg : hold_cnt_reg + 8'd1;
`endif
            if (bus.done || owner_drop || limit_hit) begin
               state_next   = ARB_IDLE;
               gnt_next     = '0;
               gnt_id_next  = '0;
               last_id_next = gnt_id_reg;
`ifdef RR_ARB_TIMEOUT_EN
               // A forced release only reports timeout when nothing else released it.
               timeout_next = limit_hit && !bus.done && !owner_drop;
`endif
            end
         end
         default: state_next = ARB_IDLE;
      endcase
   end

   assign bus.gnt       = gnt_reg;
   assign bus.gnt_id    = gnt_id_reg;
   assign bus.gnt_valid = |gnt_reg;
`ifdef RR_ARB_TIMEOUT_EN
   assign bus.timeout   = timeout_reg;
`else
   assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Directed self-checking bench for rr_req_arbiter (covers both RR_ARB_TIMEOUT_EN builds).
module tb_rr_req_arbiter;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   rr_req_arbiter_if bus ();

   rr_req_arbiter #(.MAX_HOLD(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] id, input logic t);
      chk({tag, ".gnt"}, 8'(bus.gnt), 8'(g));
      chk({tag, ".gnt_id"}, 8'(bus.gnt_id), 8'(id));
      chk({tag, ".gnt_valid"}, 8'(bus.gnt_valid), 8'(|g));
      chk({tag, ".timeout"}, 8'(bus.timeout), 8'(t));
      $display("t=%0t %s req=%b done=%b gnt=%b gnt_id=%0d timeout=%b",
               $time, tag, bus.req, bus.done, bus.gnt, bus.gnt_id, bus.timeout);
   endtask

   logic [3:0] rot_gnt [0:3];

   initial begin
      vectors     = 0;
      miscompares = 0;
      rot_gnt[0]  = 4'b0001;
      rot_gnt[1]  = 4'b0010;
      rot_gnt[2]  = 4'b0100;
      rot_gnt[3]  = 4'b1000;
      rst         = 1'b1;
      bus.req     = 4'b0000;
      bus.done    = 1'b0;

      #12;
      chk_out("reset", 4'b0000, 2'd0, 1'b0);
      rst     = 1'b0;
      bus.req = 4'b1111;

      // Fairness: 0,1,2,3 with a one-cycle done after each grant
      for (int k = 0; k < 4; k++) begin
         step();
         chk_out($sformatf("rr_grant%0d", k), rot_gnt[k], 2'(k), 1'b0);
         bus.done = 1'b1;
         step();
         chk_out($sformatf("rr_idle%0d", k), 4'b0000, 2'd0, 1'b0);
         bus.done = 1'b0;
      end
      step();
      chk_out("rr_wrap", 4'b0001, 2'd0, 1'b0);

      // Owner 0 drops its request
      bus.req = 4'b0000;
      step();
      chk_out("drop0", 4'b0000, 2'd0, 1'b0);
      bus.req = 4'b0101;
      step();
      chk_out("grant2", 4'b0100, 2'd2, 1'b0);
      bus.req = 4'b0001;
      step();
      chk_out("drop2", 4'b0000, 2'd0, 1'b0);
      step();
      chk_out("wrap_to0", 4'b0001, 2'd0, 1'b0);

      // done and req drop together: single release, one idle cycle
      bus.done = 1'b1;
      bus.req  = 4'b0010;
      step();
      chk_out("dual_release", 4'b0000, 2'd0, 1'b0);
      bus.done = 1'b0;
      step();
      chk_out("grant1", 4'b0010, 2'd1, 1'b0);

      // Held request with no done: first grant cycle already observed
`ifdef RR_ARB_TIMEOUT_EN
      for (int c = 2; c <= 16; c++) begin
         step();
         chk_out($sformatf("hold%0d", c), 4'b0010, 2'd1, 1'b0);
      end
      step();
      chk_out("forced_release", 4'b0000, 2'd0, 1'b1);
      step();
      chk_out("regrant1", 4'b0010, 2'd1, 1'b0);
`else
      for (int c = 2; c <= 100; c++) begin
         step();
         chk_out($sformatf("hold%0d", c), 4'b0010, 2'd1, 1'b0);
      end
`endif

      // done while idle is ignored; then owner 3 granted
      bus.req = 4'b0000;
      step();
      chk_out("drop1", 4'b0000, 2'd0, 1'b0);
      bus.done = 1'b1;
      step();
      chk_out("idle_done", 4'b0000, 2'd0, 1'b0);
      bus.done = 1'b0;
      bus.req  = 4'b1000;
      step();
      chk_out("grant3", 4'b1000, 2'd3, 1'b0);

      // Asynchronous reset mid-grant, away from any clock edge
      #3;
      rst = 1'b1;
      #1;
      chk_out("async_rst", 4'b0000, 2'd0, 1'b0);
      bus.req = 4'b1001;
      step();
      step();
      rst = 1'b0;
      step();
      chk_out("post_rst", 4'b0001, 2'd0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
